jttrack_objbuf: RTL and testbench



---
 rtl/jttrack_objbuf_pkg.sv | 20 ++
 rtl/jttrack_objbuf_if.sv | 12 +
 rtl/jtframe_dual_ram.sv | 24 ++
 rtl/jttrack_objbuf.sv | 117 +++++++++++
 tb/tb_jttrack_objbuf.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jttrack_objbuf_pkg.sv
// Shared constants and types for the track object line buffer.
package jttrack_objbuf_pkg;

    localparam int              OBJ_AW         = 8;     // 256 dots per line
    localparam int              OBJ_DW         = 4;     // 4-bit object colour
    localparam logic [3:0]      CLR_COLOUR_DEF = 4'd0;  // erase value, also transparent

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } objbuf_state_t;

    // Display read address: offset the dot counter, then mirror it for flip.
    function automatic logic [7:0] rd_addr(input logic [7:0] h,
                                           input logic [7:0] offset,
                                           input logic       flip);
        return (h + offset) ^ {8{flip}};
    endfunction

endpackage

// File: rtl/jttrack_objbuf_if.sv
// Draw-side pixel bus from the object drawer into the line buffer.
interface jttrack_objbuf_if;
    import jttrack_objbuf_pkg::*;

    logic [OBJ_AW-1:0] wr_addr;
    logic [OBJ_DW-1:0] wr_data;
    logic              wr_en;

    modport master (output wr_addr, output wr_data, output wr_en);
    modport slave  (input  wr_addr, input  wr_data, input  wr_en);

endinterface

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module jtframe_dual_ram #(
    parameter int AW = 8,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [2**AW];

    // Write port and registered read port.
    // NOTE: no reset on the array so it maps to block RAM; the owner clears it
    // NOTE: sequential state uses <= so all flops update from pre-edge values
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        q <= mem[raddr];
    end

endmodule

// File: rtl/jttrack_objbuf.sv
// Double-buffered object line buffer: the drawer fills one bank while the
// other is read out in step with hdump and erased behind the read.
module jttrack_objbuf
    import jttrack_objbuf_pkg::*;
#(
    parameter logic [7:0] RD_OFFSET  = 8'd0,
    parameter logic [3:0] CLR_COLOUR = CLR_COLOUR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pxl_cen,
    input  logic               hinit,
    input  logic               LHBL,
    input  logic [8:0]         hdump,
    input  logic               flip,
    jttrack_objbuf_if.slave    draw,
    output logic               busy,
    output logic [3:0]         pxl
);

    objbuf_state_t     state;
    logic              dbank;      // draw bank; ~dbank is on display
    logic [OBJ_AW-1:0] clr_cnt;
    logic              rd_pend;
    logic [OBJ_AW-1:0] ra_l;       // address to erase once data is back
    logic              rd_bank;    // bank that was read, kept across a swap

    logic [OBJ_AW-1:0] ra;
    logic              draw_we;
    logic              erase_we;

    logic              bank_we    [2];
    logic [OBJ_AW-1:0] bank_waddr [2];
    logic [OBJ_DW-1:0] bank_wdata [2];
    logic [OBJ_DW-1:0] bank_q     [2];

    logic              unused_hdump;
    assign unused_hdump = hdump[8];

    assign ra       = rd_addr(hdump[7:0], RD_OFFSET, flip);
    assign draw_we  = (state == RUN) && draw.wr_en && (draw.wr_data != CLR_COLOUR);
    assign erase_we = (state == RUN) && rd_pend;

    // Per-bank write port steering: clear sweep, draw, or erase-behind-read.
    // Draw wins over erase; the two only meet if hinit lands on a pending read.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            // NOTE: defaults first so every path assigns every output (no latches)
            bank_we[b]    = 1'b0;
            bank_waddr[b] = clr_cnt;
            bank_wdata[b] = CLR_COLOUR;
            if (state == CLEAR) begin
                bank_we[b] = 1'b1;
            end else if (draw_we && dbank == 1'(b)) begin
                bank_we[b]    = 1'b1;
                bank_waddr[b] = draw.wr_addr;
                bank_wdata[b] = draw.wr_data;
            end else if (erase_we && rd_bank == 1'(b)) begin
                bank_we[b]    = 1'b1;
                bank_waddr[b] = ra_l;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        jtframe_dual_ram #(.AW(OBJ_AW), .DW(OBJ_DW)) u_ram (
            .clk   (clk),
            .we    (bank_we[b]),
            .waddr (bank_waddr[b]),
            .wdata (bank_wdata[b]),
            .raddr (ra),
            .q     (bank_q[b])
        );
    end

    // Control FSM: clear sweep after reset, then bank swap and read/erase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
            dbank   <= 1'b0;
            pxl     <= '0;
            rd_pend <= 1'b0;
            ra_l    <= '0;
            rd_bank <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    pxl     <= '0;
                    rd_pend <= 1'b0;
                    clr_cnt <= clr_cnt + 8'd1;
                    if (clr_cnt == 8'hFF) begin
                        busy  <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (hinit) dbank <= ~dbank;
                    rd_pend <= 1'b0;
                    if (rd_pend) pxl <= bank_q[rd_bank];
                    if (pxl_cen) begin
                        if (LHBL) begin
                            rd_pend <= 1'b1;
                            ra_l    <= ra;
                            rd_bank <= ~dbank;
                        end else begin
                            pxl <= '0;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_jttrack_objbuf.sv
// Randomized bench for jttrack_objbuf against a two-bank array model.
module tb_jttrack_objbuf;

    localparam logic [7:0] OFFS = 8'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic       pxl_cen;
    logic       hinit;
    logic       LHBL;
    logic [8:0] hdump;
    logic       flip;
    logic       busy;
    logic [3:0] pxl;

    jttrack_objbuf_if bus ();

    jttrack_objbuf #(.RD_OFFSET(OFFS)) dut (
        .clk     (clk),
        .rst     (rst),
        .pxl_cen (pxl_cen),
        .hinit   (hinit),
        .LHBL    (LHBL),
        .hdump   (hdump),
        .flip    (flip),
        .draw    (bus),
        .busy    (busy),
        .pxl     (pxl)
    );

    always #5 clk = ~clk;

    // Reference model: two line banks plus the draw-bank index.
    logic [3:0] mb [2][256];
    int         mdb;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++)
                mb[b][a] = 4'd0;
        mdb = 0;
    endtask

    task automatic draw(input logic [7:0] a, input logic [3:0] d);
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        step();
        bus.wr_en   = 1'b0;
        if (d != 4'd0) mb[mdb][a] = d;
    endtask

    task automatic swap(input logic with_wr, input logic [7:0] a, input logic [3:0] d);
        hinit = 1'b1;
        if (with_wr) begin
            bus.wr_addr = a;
            bus.wr_data = d;
            bus.wr_en   = 1'b1;
        end
        step();
        hinit     = 1'b0;
        bus.wr_en = 1'b0;
        if (with_wr && d != 4'd0) mb[mdb][a] = d;
        mdb ^= 1;
    endtask

    // One dot slot of 8 clk: pxl_cen on the first, check two clk later,
    // optional random drawing in the remaining slots, then check the hold.
    task automatic dot(input logic [7:0] h, input logic f, input logic lb,
                       input logic rnd, input string tag, output logic [3:0] got);
        int         ra;
        int         disp;
        logic [3:0] exp;
        ra   = ((int'(h) + int'(OFFS)) % 256) ^ (f ? 255 : 0);
        disp = mdb ^ 1;
        exp  = lb ? mb[disp][ra] : 4'd0;
        if (lb) mb[disp][ra] = 4'd0;
        hdump   = {1'b0, h};
        flip    = f;
        LHBL    = lb;
        pxl_cen = 1'b1;
        step();
        pxl_cen = 1'b0;
        step();
        got = pxl;
        check(tag, {5'd0, pxl}, {5'd0, exp});
        for (int i = 0; i < 6; i++) begin
            if (rnd && $urandom_range(1, 0) == 1)
                draw(8'($urandom), 4'($urandom_range(15, 0)));
            else
                step();
        end
        check({tag, "_hold"}, {5'd0, pxl}, {5'd0, exp});
    endtask

    // Counts clk edges while busy is high; noise on hinit/wr_en meanwhile.
    task automatic count_busy(output int n);
        n = 0;
        bus.wr_addr = 8'h40;
        bus.wr_data = 4'h7;
        while (busy === 1'b1 && n < 600) begin
            hinit     = (n < 101);
            bus.wr_en = 1'b1;
            step();
            n++;
        end
        hinit     = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [3:0] got;
        int         n;
        logic [7:0] tgt;
        logic       f;

        rst = 1'b1; pxl_cen = 1'b0; hinit = 1'b0; LHBL = 1'b1;
        hdump = '0; flip = 1'b0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.wr_en = 1'b0;
        step();
        step();

        // Reset and the full clear sweep.
        do_reset();
        check("rst_busy", {8'd0, busy}, 9'd1);
        check("rst_pxl", {5'd0, pxl}, 9'd0);
        count_busy(n);
        check("busy_len", 9'(n), 9'd256);
        check("busy_low", {8'd0, busy}, 9'd0);

        // A whole visible line after the sweep must be transparent.
        swap(1'b0, 8'h00, 4'h0);
        for (int h = 0; h < 256; h++)
            dot(8'(h), 1'b0, 1'b1, 1'b0, "clr_line", got);

        // Write, read back, and confirm it was erased behind the read.
        draw(8'h40, 4'h7);
        swap(1'b0, 8'h00, 4'h0);
        dot(8'h3E, 1'b0, 1'b1, 1'b0, "wr_rd", got);
        check("wr_rd_const", {5'd0, got}, 9'h7);
        swap(1'b0, 8'h00, 4'h0);
        swap(1'b0, 8'h00, 4'h0);
        dot(8'h3E, 1'b0, 1'b1, 1'b0, "erased", got);
        check("erased_const", {5'd0, got}, 9'h0);

        // Transparent writes are dropped, later opaque writes win.
        draw(8'h40, 4'h5);
        draw(8'h40, 4'h0);
        draw(8'h41, 4'h3);
        draw(8'h41, 4'h9);
        swap(1'b0, 8'h00, 4'h0);
        dot(8'h3E, 1'b0, 1'b1, 1'b0, "transp", got);
        check("transp_const", {5'd0, got}, 9'h5);
        dot(8'h3F, 1'b0, 1'b1, 1'b0, "overwr", got);
        check("overwr_const", {5'd0, got}, 9'h9);

        // Flip with offset, including the 8-bit wrap.
        swap(1'b0, 8'h00, 4'h0);
        draw(8'hFD, 4'hA);
        draw(8'hFE, 4'hB);
        swap(1'b0, 8'h00, 4'h0);
        dot(8'h00, 1'b1, 1'b1, 1'b0, "flip", got);
        check("flip_const", {5'd0, got}, 9'hA);
        dot(8'hFF, 1'b1, 1'b1, 1'b0, "flip_wrap", got);
        check("flip_wrap_const", {5'd0, got}, 9'hB);

        // Write on the hinit edge lands in the bank that was drawing.
        swap(1'b1, 8'h10, 4'h6);
        swap(1'b0, 8'h00, 4'h0);
        dot(8'h0E, 1'b0, 1'b1, 1'b0, "hw_newbank", got);
        check("hw_newbank_const", {5'd0, got}, 9'h0);
        swap(1'b0, 8'h00, 4'h0);
        dot(8'h0E, 1'b0, 1'b1, 1'b0, "hw_oldbank", got);
        check("hw_oldbank_const", {5'd0, got}, 9'h6);

        // Blanked dot outputs 0 and leaves the buffer intact.
        swap(1'b0, 8'h00, 4'h0);
        draw(8'h20, 4'hC);
        swap(1'b0, 8'h00, 4'h0);
        dot(8'h1E, 1'b0, 1'b0, 1'b0, "blank", got);
        check("blank_const", {5'd0, got}, 9'h0);
        dot(8'h1E, 1'b0, 1'b1, 1'b0, "kept", got);
        check("kept_const", {5'd0, got}, 9'hC);

        // Random lines: draws clustered on 32 addresses, dots mostly aimed there.
        for (int line = 0; line < 30; line++) begin
            for (int k = 0; k < 25; k++)
                draw(8'($urandom_range(31, 0)), 4'($urandom_range(15, 0)));
            if ($urandom_range(3, 0) == 0)
                swap(1'b1, 8'($urandom_range(31, 0)), 4'($urandom_range(15, 0)));
            else
                swap(1'b0, 8'h00, 4'h0);
            for (int k = 0; k < 40; k++) begin
                f   = 1'($urandom_range(1, 0));
                tgt = 8'($urandom_range(31, 0));
                if ($urandom_range(3, 0) == 0)
                    tgt = 8'($urandom);
                else
                    tgt = (tgt ^ {8{f}}) - OFFS;
                dot(tgt, f, ($urandom_range(9, 0) != 0), 1'b1, "rnd", got);
            end
        end

        // Reset partway through a sweep restarts it from zero.
        for (int a = 0; a < 16; a++) draw(8'(a), 4'(a | 1));
        swap(1'b0, 8'h00, 4'h0);
        for (int a = 0; a < 16; a++) draw(8'(a), 4'hF);
        do_reset();
        repeat (100) step();
        check("mid_busy", {8'd0, busy}, 9'd1);
        do_reset();
        count_busy(n);
        check("mid_busy_len", 9'(n), 9'd256);
        for (int s = 0; s < 2; s++) begin
            swap(1'b0, 8'h00, 4'h0);
            for (int a = 0; a < 16; a++)
                dot(8'(a) - OFFS, 1'b0, 1'b1, 1'b0, "mid_clr", got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
